// File: rtl/edge_scan_rasterizer.sv
// Column-slice triangle rasterizer: edge functions are set up once per task,
// then an additive column-major scan streams covered pixels over valid/ready.
module edge_scan_rasterizer #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned X_START = 0,
   parameter int unsigned X_END   = 29,
   parameter int unsigned HEIGHT  = 480,
   parameter int unsigned COLOR_W = 24,
   parameter int unsigned DEPTH_W = 8
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_task_valid,
   output logic               o_task_ready,
   input  logic [COORD_W-1:0] i_ax,
   input  logic [COORD_W-1:0] i_ay,
   input  logic [COORD_W-1:0] i_bx,
   input  logic [COORD_W-1:0] i_by,
   input  logic [COORD_W-1:0] i_cx,
   input  logic [COORD_W-1:0] i_cy,
   input  logic [COLOR_W-1:0] i_task_color,
   input  logic [DEPTH_W-1:0] i_task_depth,
   output logic               o_pix_valid,
   input  logic               i_pix_ready,
   output logic [COORD_W-1:0] o_pix_x,
   output logic [COORD_W-1:0] o_pix_y,
   output logic [COLOR_W-1:0] o_pix_color,
   output logic [DEPTH_W-1:0] o_pix_depth,
   output logic               o_busy,
   output logic               o_task_done
);
   localparam int unsigned DIFF_W = COORD_W + 1;
   localparam int unsigned ACC_W  = 2 * COORD_W + 4;
   localparam logic [COORD_W-1:0] XS   = COORD_W'(X_START);
   localparam logic [COORD_W-1:0] XE   = COORD_W'(X_END);
   localparam logic [COORD_W-1:0] YMAX = COORD_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_BBOX, S_SETUP0, S_SETUP1, S_SETUP2, S_SCAN, S_DRAIN, S_DONE
   } state_t;

   state_t                     r_state;
   logic                       r_task_ready;
   logic                       r_busy;
   logic                       r_task_done;
   logic [COORD_W-1:0]         r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   logic [COLOR_W-1:0]         r_color;
   logic [DEPTH_W-1:0]         r_depth;
   logic [COORD_W-1:0]         r_x0, r_x1, r_y0, r_y1;
   logic [COORD_W-1:0]         r_cur_x, r_cur_y;
   logic                       r_area_pos;
   logic signed [ACC_W-1:0]    r_col_e [3];
   logic signed [ACC_W-1:0]    r_run_e [3];
   logic                       r_pix_valid;
   logic [COORD_W-1:0]         r_pix_x, r_pix_y;
   logic [COLOR_W-1:0]         r_pix_color;
   logic [DEPTH_W-1:0]         r_pix_depth;

   logic signed [DIFF_W-1:0]   w_dx [3];
   logic signed [DIFF_W-1:0]   w_dy [3];
   logic [COORD_W-1:0]         w_ev_px, w_ev_py, w_ev_qx, w_ev_qy, w_ev_x, w_ev_y;
   logic signed [ACC_W-1:0]    w_ev_e;
   logic [COORD_W-1:0]         w_minx, w_maxx, w_miny, w_maxy;
   logic [COORD_W-1:0]         w_bx0, w_bx1, w_by1;
   logic                       w_empty;
   logic                       w_all_ge, w_all_le, w_inside, w_free;

   function automatic logic signed [DIFF_W-1:0] diff(input logic [COORD_W-1:0] q,
                                                      input logic [COORD_W-1:0] p);
      return $signed({1'b0, q}) - $signed({1'b0, p});
   endfunction

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Per-edge scan increments: +dx per row step, -dy per column step.
   always_comb begin
      w_dx[0] = diff(r_bx, r_ax);
      w_dy[0] = diff(r_by, r_ay);
      w_dx[1] = diff(r_cx, r_bx);
      w_dy[1] = diff(r_cy, r_by);
      w_dx[2] = diff(r_ax, r_cx);
      w_dy[2] = diff(r_ay, r_cy);
   end

   // One shared edge evaluator: area in BBOX, one edge at (x0,y0) per SETUP cycle.
   always_comb begin
      w_ev_px = r_ax;
      w_ev_py = r_ay;
      w_ev_qx = r_bx;
      w_ev_qy = r_by;
      w_ev_x  = r_x0;
      w_ev_y  = r_y0;
      case (r_state)
         S_BBOX: begin
            w_ev_x = r_cx;
            w_ev_y = r_cy;
         end
         S_SETUP1: begin
            w_ev_px = r_bx;
            w_ev_py = r_by;
            w_ev_qx = r_cx;
            w_ev_qy = r_cy;
         end
         S_SETUP2: begin
            w_ev_px = r_cx;
            w_ev_py = r_cy;
            w_ev_qx = r_ax;
            w_ev_qy = r_ay;
         end
         default: ;
      endcase
      w_ev_e = ACC_W'(diff(w_ev_qx, w_ev_px)) * ACC_W'(diff(w_ev_y, w_ev_py))
             - ACC_W'(diff(w_ev_qy, w_ev_py)) * ACC_W'(diff(w_ev_x, w_ev_px));
   end

   always_comb begin
      w_minx  = min3(r_ax, r_bx, r_cx);
      w_maxx  = max3(r_ax, r_bx, r_cx);
      w_miny  = min3(r_ay, r_by, r_cy);
      w_maxy  = max3(r_ay, r_by, r_cy);
      w_bx0   = (w_minx < XS) ? XS : w_minx;
      w_bx1   = (w_maxx > XE) ? XE : w_maxx;
      w_by1   = (w_maxy > YMAX) ? YMAX : w_maxy;
      w_empty = (w_ev_e == '0) || (w_bx0 > w_bx1) || (w_miny > w_by1);
   end

   always_comb begin
      w_all_ge = !r_run_e[0][ACC_W-1] && !r_run_e[1][ACC_W-1] && !r_run_e[2][ACC_W-1];
      w_all_le = (r_run_e[0][ACC_W-1] || (r_run_e[0] == '0))
              && (r_run_e[1][ACC_W-1] || (r_run_e[1] == '0))
              && (r_run_e[2][ACC_W-1] || (r_run_e[2] == '0));
      w_inside = r_area_pos ? w_all_ge : w_all_le;
      w_free   = !r_pix_valid || i_pix_ready;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_task_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_task_done  <= 1'b0;
         r_ax <= '0; r_ay <= '0; r_bx <= '0; r_by <= '0; r_cx <= '0; r_cy <= '0;
         r_color      <= '0;
         r_depth      <= '0;
         r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
         r_cur_x      <= '0;
         r_cur_y      <= '0;
         r_area_pos   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_col_e[i] <= '0;
            r_run_e[i] <= '0;
         end
         r_pix_valid  <= 1'b0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_pix_color  <= '0;
         r_pix_depth  <= '0;
      end else begin
         r_task_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_task_ready <= 1'b1;
               if (i_task_valid && r_task_ready) begin
                  r_ax <= i_ax; r_ay <= i_ay; r_bx <= i_bx;
                  r_by <= i_by; r_cx <= i_cx; r_cy <= i_cy;
                  r_color      <= i_task_color;
                  r_depth      <= i_task_depth;
                  r_task_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_BBOX;
               end
            end
            S_BBOX: begin
               r_x0       <= w_bx0;
               r_x1       <= w_bx1;
               r_y0       <= w_miny;
               r_y1       <= w_by1;
               r_area_pos <= !w_ev_e[ACC_W-1];
               if (w_empty) begin
                  r_task_done <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_state <= S_SETUP0;
               end
            end
            S_SETUP0: begin
               r_col_e[0] <= w_ev_e;
               r_run_e[0] <= w_ev_e;
               r_cur_x    <= r_x0;
               r_cur_y    <= r_y0;
               r_state    <= S_SETUP1;
            end
            S_SETUP1: begin
               r_col_e[1] <= w_ev_e;
               r_run_e[1] <= w_ev_e;
               r_state    <= S_SETUP2;
            end
            S_SETUP2: begin
               r_col_e[2] <= w_ev_e;
               r_run_e[2] <= w_ev_e;
               r_state    <= S_SCAN;
            end
            S_SCAN: begin
               // Scan state only advances when the output register can take a result.
               if (w_free) begin
                  r_pix_valid <= w_inside;
                  if (w_inside) begin
                     r_pix_x     <= r_cur_x;
                     r_pix_y     <= r_cur_y;
                     r_pix_color <= r_color;
                     r_pix_depth <= r_depth;
                  end
                  if (r_cur_y == r_y1) begin
                     if (r_cur_x == r_x1) begin
                        r_state <= S_DRAIN;
                     end else begin
                        r_cur_x <= r_cur_x + COORD_W'(1);
                        r_cur_y <= r_y0;
                        for (int i = 0; i < 3; i++) begin
                           r_col_e[i] <= r_col_e[i] - ACC_W'(w_dy[i]);
                           r_run_e[i] <= r_col_e[i] - ACC_W'(w_dy[i]);
                        end
                     end
                  end else begin
                     r_cur_y <= r_cur_y + COORD_W'(1);
                     for (int i = 0; i < 3; i++) begin
                        r_run_e[i] <= r_run_e[i] + ACC_W'(w_dx[i]);
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (w_free) begin
                  r_pix_valid <= 1'b0;
                  r_task_done <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy       <= 1'b0;
               r_task_ready <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_task_ready = r_task_ready;
   assign o_busy       = r_busy;
   assign o_task_done  = r_task_done;
   assign o_pix_valid  = r_pix_valid;
   assign o_pix_x      = r_pix_x;
   assign o_pix_y      = r_pix_y;
   assign o_pix_color  = r_pix_color;
   assign o_pix_depth  = r_pix_depth;
endmodule
